// File: rtl/unidade_pc_pkg.sv
// Shared definitions for the program-counter unit: PC width, FSM state
// encodings and the default reset vector.
package unidade_pc_pkg;

  localparam int LARGURA_PC = 8;

  localparam logic [LARGURA_PC-1:0] PC_INICIAL_PADRAO = 8'h00;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } estado_t;

endpackage : unidade_pc_pkg

// File: rtl/somador_pc.sv
// Next-sequential / branch-target adder for the program counter.
// Adds either the branch displacement or one; the carry out is dropped so the PC wraps.
module somador_pc
  import unidade_pc_pkg::*;
(
  input  logic                  i_branch,
  input  logic [LARGURA_PC-1:0] i_pc,
  input  logic [LARGURA_PC-1:0] i_offset,
  output logic [LARGURA_PC-1:0] o_soma
);

  logic [LARGURA_PC-1:0] w_incremento;

  // A two's-complement offset added at full PC width behaves as sign-extended.
  assign w_incremento = i_branch ? i_offset : LARGURA_PC'(1);
  assign o_soma       = i_pc + w_incremento;

endmodule : somador_pc

// File: rtl/unidade_pc.sv
// Program-counter unit: next-PC selection, RUN/HALTED control and a
// saturating count of PC advances since reset.
module unidade_pc
  import unidade_pc_pkg::*;
#(
  parameter logic [LARGURA_PC-1:0] PC_INICIAL   = PC_INICIAL_PADRAO,
  parameter int                    LARGURA_CONT = 16
)(
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Stall,
  input  logic                    Halt,
  input  logic                    Jump,
  input  logic [LARGURA_PC-1:0]   JumpAddr,
  input  logic                    Branch,
  input  logic [LARGURA_PC-1:0]   Offset,
  output logic [LARGURA_PC-1:0]   Endereco,
  output logic                    Parado,
  output logic [LARGURA_CONT-1:0] Contagem
);

  localparam logic [LARGURA_CONT-1:0] CONT_UM = LARGURA_CONT'(1);

  estado_t                 r_estado;
  logic [LARGURA_PC-1:0]   r_pc;
  logic                    r_parado;
  logic [LARGURA_CONT-1:0] r_contagem;

  logic [LARGURA_PC-1:0]   w_soma;
  logic [LARGURA_PC-1:0]   w_proximoPc;

  somador_pc u_somador (
    .i_branch (Branch),
    .i_pc     (r_pc),
    .i_offset (Offset),
    .o_soma   (w_soma)
  );

  // Jump beats branch; the adder already chose between branch and sequential.
  assign w_proximoPc = Jump ? JumpAddr : w_soma;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_estado   <= RUN;
      r_pc       <= PC_INICIAL;
      r_parado   <= 1'b0;
      r_contagem <= '0;
    end else begin
      case (r_estado)
        RUN: begin
          if (!Stall) begin
            if (Halt) begin
              r_estado <= HALTED;
              r_parado <= 1'b1;
            end else begin
              r_pc <= w_proximoPc;
              // Saturate rather than wrap so an overflowed count is still recognisable.
              if (r_contagem != '1) begin
                r_contagem <= r_contagem + CONT_UM;
              end
            end
          end
        end
        HALTED: begin
          r_parado <= 1'b1;
        end
        default: begin
          r_estado <= RUN;
          r_parado <= 1'b0;
        end
      endcase
    end
  end

  assign Endereco = r_pc;
  assign Parado   = r_parado;
  assign Contagem = r_contagem;

endmodule : unidade_pc

// File: tb/tb_unidade_pc.sv
// Directed self-checking bench for unidade_pc, plus a narrow-counter instance
// with a non-zero reset vector to exercise counter saturation quickly.
module tb_unidade_pc;

  logic        Clock;
  logic        Reset;
  logic        Stall;
  logic        Halt;
  logic        Jump;
  logic [7:0]  JumpAddr;
  logic        Branch;
  logic [7:0]  Offset;
  logic [7:0]  Endereco;
  logic        Parado;
  logic [15:0] Contagem;

  logic        satZero;
  logic [7:0]  satZeroByte;
  logic [7:0]  satEndereco;
  logic        satParado;
  logic [3:0]  satContagem;

  int testsRun;
  int testsFailed;

  unidade_pc #(
    .PC_INICIAL   (8'h00),
    .LARGURA_CONT (16)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Stall    (Stall),
    .Halt     (Halt),
    .Jump     (Jump),
    .JumpAddr (JumpAddr),
    .Branch   (Branch),
    .Offset   (Offset),
    .Endereco (Endereco),
    .Parado   (Parado),
    .Contagem (Contagem)
  );

  unidade_pc #(
    .PC_INICIAL   (8'h40),
    .LARGURA_CONT (4)
  ) dutSat (
    .Clock    (Clock),
    .Reset    (Reset),
    .Stall    (satZero),
    .Halt     (satZero),
    .Jump     (satZero),
    .JumpAddr (satZeroByte),
    .Branch   (satZero),
    .Offset   (satZeroByte),
    .Endereco (satEndereco),
    .Parado   (satParado),
    .Contagem (satContagem)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests, clock it in, and settle just after the edge.
  task automatic applyStimulus(input logic rst, input logic stl, input logic hlt,
                               input logic jmp, input logic [7:0] jAddr,
                               input logic brn, input logic [7:0] off);
    Reset    = rst;
    Stall    = stl;
    Halt     = hlt;
    Jump     = jmp;
    JumpAddr = jAddr;
    Branch   = brn;
    Offset   = off;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    satZero     = 1'b0;
    satZeroByte = 8'h00;
    Reset = 1'b1; Stall = 1'b0; Halt = 1'b0; Jump = 1'b0;
    JumpAddr = 8'h00; Branch = 1'b0; Offset = 8'h00;
    #2;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("reset pc", Endereco, 8'h00);
    checkOutput("reset parado", Parado, 1'b0);
    checkOutput("reset contagem", Contagem, 16'd0);
    checkOutput("reset vector param", satEndereco, 8'h40);

    for (int i = 1; i <= 5; i++) begin
      idle();
      checkOutput($sformatf("seq pc %0d", i), Endereco, 32'(i));
    end
    checkOutput("seq contagem", Contagem, 16'd5);
    checkOutput("seq parado", Parado, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h14, 1'b1, 8'h03);
    checkOutput("stall+jump pc", Endereco, 8'h05);
    checkOutput("stall+jump contagem", Contagem, 16'd5);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("stall+halt parado", Parado, 1'b0);
    checkOutput("stall+halt pc", Endereco, 8'h05);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h14, 1'b1, 8'h03);
    checkOutput("jump beats branch", Endereco, 8'h14);
    checkOutput("jump contagem", Contagem, 16'd6);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
    checkOutput("jump to 10", Endereco, 8'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFD);
    checkOutput("branch back", Endereco, 8'h0D);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03);
    checkOutput("branch fwd", Endereco, 8'h13);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    checkOutput("branch zero pc", Endereco, 8'h13);
    checkOutput("branch zero contagem", Contagem, 16'd11);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
    idle();
    checkOutput("wrap pc", Endereco, 8'h00);
    checkOutput("wrap contagem", Contagem, 16'd13);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("halt parado", Parado, 1'b1);
    checkOutput("halt pc", Endereco, 8'h15);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, i[2], 1'b0, i[0], 8'h33, ~i[0], 8'h07);
      checkOutput($sformatf("halted pc %0d", i), Endereco, 8'h15);
    end
    checkOutput("halted parado", Parado, 1'b1);
    checkOutput("halted contagem", Contagem, 16'd14);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00);
    checkOutput("exit halt pc", Endereco, 8'h00);
    checkOutput("exit halt parado", Parado, 1'b0);
    checkOutput("exit halt contagem", Contagem, 16'd0);

    for (int i = 0; i < 8; i++) idle();
    checkOutput("pre-reset pc", Endereco, 8'h08);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05);
    checkOutput("reset over stall", Endereco, 8'h00);
    checkOutput("reset over stall cont", Contagem, 16'd0);
    idle();
    checkOutput("post-reset pc", Endereco, 8'h01);
    checkOutput("post-reset contagem", Contagem, 16'd1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 14; i++) idle();
    checkOutput("sat before", satContagem, 4'd14);
    idle();
    checkOutput("sat reach", satContagem, 4'd15);
    for (int i = 0; i < 3; i++) idle();
    checkOutput("sat hold", satContagem, 4'd15);
    checkOutput("sat pc", satEndereco, 8'h52);
    checkOutput("sat parado", satParado, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_unidade_pc

// File: doc/unidade_pc.md
UNIDADE_PC -- requirements
Module: unidade_pc

Interface
REQ-001 SHALL have parameter: PC_INICIAL, 8'h00, reset vector loaded into the program counter.
REQ-002 SHALL have parameter: LARGURA_CONT, 16, width of the retired-instruction counter.
REQ-003 SHALL have port: Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: Stall  input  1  hold all state this cycle.
REQ-006 SHALL have port: Halt  input  1  halt instruction decoded at current PC.
REQ-007 SHALL have port: Jump  input  1  jump-register request (njre).
REQ-008 SHALL have port: JumpAddr  input  8  absolute jump target.
REQ-009 SHALL have port: Branch  input  1  taken-branch request (nbeqz, condition true).
REQ-010 SHALL have port: Offset  input  8  signed two's-complement branch displacement.
REQ-011 SHALL have port: Endereco  output  8  registered PC, drives the instruction memory address.
REQ-012 SHALL have port: Parado  output  1  high while in state HALTED.
REQ-013 SHALL have port: Contagem  output  LARGURA_CONT  number of PC advances since reset.

Function
REQ-014 SHALL implement FSM with two states: RUN, HALTED.
REQ-015 In RUN, per cycle, SHALL select next PC by priority: Stall > Halt > Jump > Branch > sequential.
REQ-016 Stall high: PC, state, Contagem unchanged; all other requests ignored that cycle.
REQ-017 Halt high (no Stall): PC unchanged, state -> HALTED next edge, Contagem unchanged.
REQ-018 Jump high: PC <= JumpAddr.
REQ-019 Branch high (no Jump): PC <= PC + Offset, computed modulo 256 (Offset sign-extended, carry discarded).
REQ-020 Sequential: PC <= PC + 1, modulo 256 (8'hFF wraps to 8'h00).
REQ-021 Jump, Branch or sequential update SHALL increment Contagem by 1; Contagem saturates at all-ones and never wraps.
REQ-022 In HALTED: PC, Contagem frozen; Stall, Halt, Jump, Branch ignored; only Reset exits.
REQ-023 Endereco SHALL equal the PC register directly (zero combinational logic from inputs); new PC visible one cycle after the request edge.
REQ-024 Parado SHALL be registered, high exactly in cycles where state = HALTED.
REQ-025 Branch with Offset = 8'h00 SHALL hold PC but still count as an advance (Contagem +1).

Reset
REQ-026 Reset high at a rising edge SHALL set PC = PC_INICIAL, state = RUN, Parado = 0, Contagem = 0, overriding every other input including Stall.
REQ-027 Reset mid-operation (any state, any pending request) SHALL take effect on that edge only; the first post-reset edge with Reset low SHALL apply normal RUN rules from PC_INICIAL.
REQ-028 Outputs before the first reset edge are don't-care.

Structure
REQ-029 Shared package SHALL hold: PC width (8), state encodings RUN/HALTED, default reset vector 8'h00.
REQ-030 SHALL instantiate one sub-module somador_pc: 8-bit adder computing PC + (Branch ? Offset : 8'h01), carry discarded.
REQ-031 Next-PC mux, FSM and counter SHALL reside in unidade_pc; implementation 120-400 lines RTL.

Verification
REQ-032 Reset, then 5 idle cycles -> Endereco 00,01,02,03,04,05; Contagem = 5; Parado = 0.
REQ-033 PC = 8'h10, Branch = 1, Offset = 8'hFD -> next Endereco = 8'h0D; Offset = 8'h03 from 8'h10 -> 8'h13.
REQ-034 PC = 8'h05, Jump = 1, JumpAddr = 8'h14, Branch = 1 same cycle -> Endereco = 8'h14 (Jump wins); Stall + Jump -> PC stays 8'h05.
REQ-035 PC = 8'hFF sequential -> 8'h00; Contagem preset near 16'hFFFF, 3 advances -> stays 16'hFFFF.
REQ-036 PC = 8'h15, Halt = 1 -> Parado = 1 next cycle, Endereco stays 8'h15 for 10 cycles despite Jump/Branch pulses; Reset -> Endereco = 8'h00, Parado = 0, Contagem = 0.
REQ-037 Reset asserted while Stall = 1 and Branch = 1 at PC = 8'h08 -> Endereco = 8'h00 next cycle.
